uart_tx_slave: RTL and testbench

Memory-mapped UART transmitter that sits on one slave port of the SoC bus and answers the bus's per-slave address/write-data/write-enable/read-data signals. Software (the execute stage) or the JTAG master writes bytes into a small TX FIFO. A baud-rate state machine serialises them as 8N1 frames on a single output pin. It also gives the core a console output path without involving the bus arbiter in any timing.

---
 rtl/uart_tx_slave_pkg.sv | 32 +++
 rtl/uart_tx_slave_if.sv | 25 ++
 rtl/uart_tx_slave_sync_fifo.sv | 53 +++++
 rtl/uart_tx_slave.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_slave.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_slave_pkg.sv
// uart_tx_slave shared definitions: bus widths, register map, FSM states.
// Imported by the interface, the FIFO and the top.
package uart_tx_slave_pkg;

  localparam int MemAddrBus = 32;
  localparam int MemBus     = 32;

  localparam logic [3:0] UART_CTRL   = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_BAUD   = 4'h8;
  localparam logic [3:0] UART_TXDATA = 4'hC;

  localparam int UART_ST_BUSY  = 0;
  localparam int UART_ST_FULL  = 1;
  localparam int UART_ST_EMPTY = 2;
  localparam int UART_ST_OVF   = 3;
  localparam int UART_ST_CNT   = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic logic [15:0] eff_baud(
    input logic [15:0] b
  );
    return (b < 16'd2) ? 16'd2 : b;
  endfunction

endpackage

// File: rtl/uart_tx_slave_if.sv
// Per-slave bus port: address, write data, write enable, read data.
// The slave answers reads combinationally.
interface uart_tx_slave_if;
  import uart_tx_slave_pkg::*;

  logic [MemAddrBus-1:0] addr_i;
  logic [MemBus-1:0]     data_i;
  logic                  we_i;
  logic [MemBus-1:0]     data_o;

  modport master (
    output addr_i,
    output data_i,
    output we_i,
    input  data_o
  );

  modport slave (
    input  addr_i,
    input  data_i,
    input  we_i,
    output data_o
  );

endinterface

// File: rtl/uart_tx_slave_sync_fifo.sv
// Show-ahead synchronous FIFO with count; reusable by a future RX path.
// Pushes to a full FIFO are dropped even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{AW{1'b0}}, push_ok}
             - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter: CTRL/STATUS/BAUD/TXDATA registers,
// TX FIFO and a baud-rate serialiser FSM driving a registered output pin.
module uart_tx_slave
  import uart_tx_slave_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_RESET = 434
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_slave_if.slave bus,
  output logic           tx_pin_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    sel;
  logic          wr_ctrl;
  logic          wr_status;
  logic          wr_baud;
  logic          wr_txdata;

  logic          tx_en;
  logic [15:0]   baud;
  logic          overflow;

  logic          pop;
  logic [7:0]    fifo_dout;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;

  tx_state_t     state;
  tx_state_t     state_d;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_d;
  logic [15:0]   baud_cnt;
  logic [15:0]   cnt_d;
  logic [7:0]    shift;
  logic [7:0]    shift_d;
  logic          pin_d;
  logic          tick;
  logic [7:0]    st;

  logic          unused;
  assign unused = &{1'b0, bus.addr_i[31:4],
                    bus.addr_i[1:0], bus.data_i[31:16]};

  assign sel       = {bus.addr_i[3:2], 2'b00};
  assign wr_ctrl   = bus.we_i && (sel == UART_CTRL);
  assign wr_status = bus.we_i && (sel == UART_STATUS);
  assign wr_baud   = bus.we_i && (sel == UART_BAUD);
  assign wr_txdata = bus.we_i && (sel == UART_TXDATA);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .din   (bus.data_i[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en    <= 1'b0;
      baud     <= 16'(BAUD_RESET);
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) tx_en <= bus.data_i[0];
      if (wr_baud) baud  <= bus.data_i[15:0];
      if (wr_txdata && full) begin
        overflow <= 1'b1;
      end else if (wr_status && bus.data_i[UART_ST_OVF]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    st = '0;
    st[UART_ST_BUSY]  = (state != IDLE);
    st[UART_ST_FULL]  = full;
    st[UART_ST_EMPTY] = empty;
    st[UART_ST_OVF]   = overflow;
    st[UART_ST_CNT+:4] = 4'(fifo_count);
  end

  always_comb begin
    bus.data_o = '0;
    unique case (sel)
      UART_CTRL:   bus.data_o = {31'b0, tx_en};
      UART_STATUS: bus.data_o = {24'b0, st};
      UART_BAUD:   bus.data_o = {16'b0, baud};
      UART_TXDATA: bus.data_o = '0;
      default:     bus.data_o = '0;
    endcase
  end

  // >= rather than == so a mid-bit BAUD shrink ends the bit at once
  assign tick = (baud_cnt >= eff_baud(baud) - 16'd1);

  always_comb begin
    state_d = state;
    bit_d   = bit_cnt;
    cnt_d   = baud_cnt;
    shift_d = shift;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (tx_en && !empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        cnt_d = baud_cnt + 16'd1;
        if (tick) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = baud_cnt + 16'd1;
        if (tick) begin
          cnt_d   = '0;
          shift_d = shift >> 1;
          bit_d   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = baud_cnt + 16'd1;
        if (tick) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (tx_en && !empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    pin_d = 1'b1;
    if (state_d == START) pin_d = 1'b0;
    if (state_d == DATA)  pin_d = shift_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shift    <= '0;
      tx_pin_o <= 1'b1;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_d;
      baud_cnt <= cnt_d;
      shift    <= shift_d;
      tx_pin_o <= pin_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_slave.sv
// Directed bench for uart_tx_slave: register map, frame timing, FIFO
// corner cases, mid-frame control changes and mid-frame reset.
module tb_uart_tx_slave;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_BAUD   = 32'h8;
  localparam logic [31:0] A_TXDATA = 32'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_pin;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   m;
  int   lows;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_slave_if bus ();

  uart_tx_slave #(
    .FIFO_DEPTH (4),
    .BAUD_RESET (434)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tx_pin_o (tx_pin)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr_i = a;
    bus.data_i = d;
    bus.we_i   = 1'b1;
    @(negedge clk);
    bus.we_i   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string tag);
    bus.addr_i = a;
    #1;
    chk(tag, bus.data_o, exp);
  endtask

  task automatic at(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic frames(input logic [31:0] bytes, input int n,
                        input int b);
    for (int i = 0; i < n * 10 * b; i++) begin
      int f;
      int j;
      logic e;
      logic [7:0] d;
      @(negedge clk);
      f = i / (10 * b);
      j = (i % (10 * b)) / b;
      d = bytes[8*f +: 8];
      e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
      chk($sformatf("frame%0d_bit%0d", f, j),
          {31'b0, tx_pin}, {31'b0, e});
    end
  endtask

  task automatic quiet(input int n, input string tag);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!tx_pin) lows++;
    end
    chk(tag, 32'(lows), 32'd0);
  endtask

  initial begin
    bus.addr_i = '0;
    bus.data_i = '0;
    bus.we_i   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    rd(A_CTRL,   32'h0,   "rst_ctrl");
    rd(A_STATUS, 32'h4,   "rst_status");
    rd(A_BAUD,   32'd434, "rst_baud");
    rd(A_TXDATA, 32'h0,   "rst_txdata");
    chk("rst_pin", {31'b0, tx_pin}, 32'h1);

    wr(A_BAUD, 32'd4);
    wr(A_CTRL, 32'h1);
    rd(A_CTRL, 32'h1, "ctrl_rw");
    wr(A_TXDATA, 32'hA5);
    rd(A_STATUS, 32'h10, "single_count1");
    chk("single_pin_pre", {31'b0, tx_pin}, 32'h1);
    frames(32'hA5, 1, 4);
    @(negedge clk);
    rd(A_STATUS, 32'h4, "single_done");

    wr(A_CTRL, 32'h0);
    wr(A_TXDATA, 32'h11);
    wr(A_TXDATA, 32'h22);
    wr(A_TXDATA, 32'h33);
    wr(A_TXDATA, 32'h44);
    wr(A_TXDATA, 32'h55);
    rd(A_STATUS, 32'h4A, "fill_ovf");
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, 32'h42, "ovf_clear");
    wr(A_CTRL, 32'h1);
    frames(32'h44332211, 4, 4);
    @(negedge clk);
    rd(A_STATUS, 32'h4, "burst_done");

    wr(A_CTRL, 32'h0);
    wr(A_TXDATA, 32'hC1);
    wr(A_TXDATA, 32'hC2);
    wr(A_TXDATA, 32'hC3);
    wr(A_TXDATA, 32'hC4);
    rd(A_STATUS, 32'h42, "pp_full");
    wr(A_CTRL, 32'h1);
    m = cyc;
    wr(A_TXDATA, 32'h99);
    rd(A_STATUS, 32'h39, "pp_full_drop");
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, 32'h31, "pp_ovf_clear");
    at(m + 80);
    wr(A_TXDATA, 32'hD5);
    rd(A_STATUS, 32'h21, "pp_count2");
    chk("pp_start", {31'b0, tx_pin}, 32'h0);
    at(m + 89);
    wr(A_CTRL, 32'h0);
    rd(A_CTRL, 32'h0, "mid_ctrl_clr");
    at(m + 120);
    rd(A_STATUS, 32'h21, "mid_stop_busy");
    chk("mid_stop_pin", {31'b0, tx_pin}, 32'h1);
    at(m + 121);
    rd(A_STATUS, 32'h20, "mid_idle");
    quiet(60, "mid_no_next");

    wr(A_BAUD, 32'h0);
    rd(A_BAUD, 32'h0, "baud0_read");
    wr(A_CTRL, 32'h1);
    frames(32'hD5C4, 2, 2);
    @(negedge clk);
    rd(A_STATUS, 32'h4, "baud0_done");

    wr(A_BAUD, 32'd4);
    wr(A_TXDATA, 32'h52);
    m = cyc;
    wr(A_TXDATA, 32'h3C);
    rd(A_STATUS, 32'h11, "rst_mid_count");
    at(m + 17);
    chk("rst_mid_bit3", {31'b0, tx_pin}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pin", {31'b0, tx_pin}, 32'h1);
    rd(A_STATUS, 32'h4,   "rst_mid_status");
    rd(A_CTRL,   32'h0,   "rst_mid_ctrl");
    rd(A_BAUD,   32'd434, "rst_mid_baud");
    rst = 1'b0;
    wr(A_BAUD, 32'd4);
    wr(A_CTRL, 32'h1);
    quiet(60, "rst_mid_no_frame");
    rd(A_STATUS, 32'h4, "rst_mid_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
